byte_packer32: RTL and testbench
================================

BYTE_PACKER32 -- requirements
Module: byte_packer32

Interface
REQ-001 SHALL have parameter BIG_ENDIAN, default 0, which selects lane order (0: first byte in bits [7:0]; 1: first byte in bits [31:24]).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_data, input, 8 bits: byte stream data.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data valid.
REQ-006 SHALL have port in_last, input, 1 bit: current byte ends the packet.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts a byte this cycle.
REQ-008 SHALL have port out_data, output, 32 bits: packed word that feeds byteswap32 downstream.
REQ-009 SHALL have port out_keep, output, 4 bits: per-lane byte-valid mask.
REQ-010 SHALL have port out_last, output, 1 bit: word ends the packet.
REQ-011 SHALL have port out_valid, output, 1 bit: out_* valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the word.

Function
REQ-013 SHALL treat a byte as accepted when in_valid && in_ready at the clk edge, and a word as transferred when out_valid && out_ready.
REQ-014 SHALL drive in_ready = !out_valid || out_ready, combinationally, with no other dependency.
REQ-015 SHALL keep a 2-bit lane counter cnt (0..3) and a 24-bit accumulator for lanes 0..2.
REQ-016 SHALL, on an accepted byte with cnt<3 and in_last=0, store the byte in lane cnt and increment cnt; out_* SHALL be unchanged.
REQ-017 SHALL, on an accepted byte with cnt==3 or in_last=1, load the output register on the same edge and set cnt to 0: accumulated lanes plus the current byte in lane cnt, zeros in unfilled lanes, out_keep bit k=1 for lanes 0..cnt, out_last=in_last, out_valid=1.
REQ-018 SHALL have a latency of 1 cycle, from the completing byte's accept edge to out_valid high.
REQ-019 SHALL, with BIG_ENDIAN=0, place lane k at out_data[8k+7:8k] with keep bit k; with BIG_ENDIAN=1, place lane k at out_data[31-8k:24-8k] with keep bit 3-k.
REQ-020 SHALL clear out_valid after a transfer unless a new word is loaded on the same edge; a simultaneous transfer and load SHALL give back-to-back words with no bubble.
REQ-021 SHALL hold out_data, out_keep and out_last stable while out_valid && !out_ready.
REQ-022 SHALL sustain 1 byte/cycle and 1 word per 4 cycles when out_ready is held high.
REQ-023 SHALL ignore in_data and in_last when no byte is accepted.
REQ-024 SHALL let cnt wrap from 3 to 0 only through REQ-017; a single-byte packet SHALL give keep=0001 (BE: 1000), last=1.

Reset
REQ-025 SHALL, while rst=1 at a clk edge, set out_valid=0, out_data=0, out_keep=0, out_last=0, cnt=0 and accumulator=0.
REQ-026 SHALL, when rst is asserted mid-packet, discard any partial word and any pending output word; the first byte after reset SHALL go to lane 0.
REQ-027 SHALL hold in_ready=1 during and immediately after reset, because out_valid=0.

Verification
REQ-028 SHALL check: BIG_ENDIAN=0, out_ready=1, bytes 11,22,33,44 (last on 44) on consecutive cycles -> one word 0x44332211, keep=1111, last=1, one cycle after byte 44.
REQ-029 SHALL check: BIG_ENDIAN=1, same stimulus -> 0x11223344, keep=1111; feeding this into byteswap32 SHALL give 0x44332211.
REQ-030 SHALL check: BIG_ENDIAN=0, bytes AA,BB (last on BB) -> 0x0000BBAA, keep=0011, last=1.
REQ-031 SHALL check: out_ready=0 after first word of 8-byte stream 01..08 -> in_ready=0; word 0x04030201 held stable; on out_ready=1, words 0x04030201 then 0x08070605 with no loss and no duplication.
REQ-032 SHALL check: rst pulsed after 2 bytes, then 4 bytes C1..C4 (last) sent -> single word 0xC4C3C2C1, keep=1111; no residue from the pre-reset bytes.
REQ-033 SHALL check: 1000 random bytes with random in_valid, out_ready and in_last -> scoreboard matches every word, keep and last against a reference packer; zero mismatches.

Source files
------------

// File: rtl/byte_packer32.sv
// ============================================================================
// Module  : byte_packer32
// Brief   : Packs an 8-bit byte stream into 32-bit words with keep/last.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module byte_packer32 #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_keep,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready
);

  logic [1:0]  cnt_q,   cnt_d;
  logic [23:0] acc_q,   acc_d;
  logic [31:0] data_q,  data_d;
  logic [3:0]  keep_q,  keep_d;
  logic        last_q,  last_d;
  logic        valid_q, valid_d;

  logic        accept;
  logic        xfer;
  logic        complete;
  logic [31:0] acc_pad;
  logic [31:0] lanes;
  logic [3:0]  fill;
  logic [31:0] lanes_mapped;
  logic [3:0]  fill_mapped;

  // Output slot is free when empty or being drained on this edge.
  assign in_ready = !valid_q || out_ready;

  assign accept   = in_valid && in_ready;
  assign xfer     = valid_q && out_ready;
  assign complete = accept && ((cnt_q == 2'd3) || in_last);
  assign acc_pad  = {8'h00, acc_q};

  // Word in logical lane order: accumulated lanes, current byte, then zeros.
  always_comb begin
    lanes = '0;
    fill  = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(cnt_q)) begin
        lanes[8*k +: 8] = acc_pad[8*k +: 8];
      end else if (k == int'(cnt_q)) begin
        lanes[8*k +: 8] = in_data;
      end
      if (k <= int'(cnt_q)) begin
        fill[k] = 1'b1;
      end
    end
  end

  generate
    if (BIG_ENDIAN) begin : g_big_endian
      assign lanes_mapped = {lanes[7:0], lanes[15:8], lanes[23:16], lanes[31:24]};
      assign fill_mapped  = {fill[0], fill[1], fill[2], fill[3]};
    end else begin : g_little_endian
      assign lanes_mapped = lanes;
      assign fill_mapped  = fill;
    end
  endgenerate

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q;

    if (xfer) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      if (complete) begin
        // A load on the same edge as a transfer keeps the output busy.
        data_d  = lanes_mapped;
        keep_d  = fill_mapped;
        last_d  = in_last;
        valid_d = 1'b1;
        cnt_d   = 2'd0;
        acc_d   = '0;
      end else begin
        case (cnt_q)
          2'd0:    acc_d[7:0]   = in_data;
          2'd1:    acc_d[15:8]  = in_data;
          2'd2:    acc_d[23:16] = in_data;
          default: acc_d        = acc_q;
        endcase
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      acc_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_byte_packer32.sv
// ============================================================================
// Module  : tb_byte_packer32
// Brief   : Self-checking bench for byte_packer32, both lane orders at once.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_byte_packer32;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;

  logic        in_ready_le, in_ready_be;
  logic [31:0] out_data_le, out_data_be;
  logic [3:0]  out_keep_le, out_keep_be;
  logic        out_last_le, out_last_be;
  logic        out_valid_le, out_valid_be;

  always #5 clk = ~clk;

  byte_packer32 #(.BIG_ENDIAN(1'b0)) u_dut_le (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready_le), .out_data(out_data_le),
    .out_keep(out_keep_le), .out_last(out_last_le), .out_valid(out_valid_le),
    .out_ready(out_ready)
  );

  byte_packer32 #(.BIG_ENDIAN(1'b1)) u_dut_be (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready_be), .out_data(out_data_be),
    .out_keep(out_keep_be), .out_last(out_last_be), .out_valid(out_valid_be),
    .out_ready(out_ready)
  );

  typedef struct {
    logic [31:0] dle;
    logic [31:0] dbe;
    logic [3:0]  kle;
    logic [3:0]  kbe;
    logic        last;
  } word_t;

  // Reference: bytes of the open word, and words awaiting transfer.
  logic [7:0] pend[$];
  word_t      wq[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void make_word(input logic lst);
    word_t w;
    w.dle  = '0;
    w.dbe  = '0;
    w.kle  = '0;
    w.kbe  = '0;
    w.last = lst;
    for (int k = 0; k < pend.size(); k++) begin
      w.dle = w.dle | (32'(pend[k]) << (8 * k));
      w.dbe = w.dbe | (32'(pend[k]) << (24 - 8 * k));
      w.kle[k]     = 1'b1;
      w.kbe[3 - k] = 1'b1;
    end
    wq.push_back(w);
    pend.delete();
  endfunction

  // One clock: check outputs against the reference, then advance it.
  task automatic step(output bit accepted);
    bit   ev, exp_rdy, xf, s_rst, s_last;
    logic [7:0] s_data;
    @(negedge clk);
    ev      = (wq.size() != 0);
    exp_rdy = !ev || out_ready;
    chk("in_ready_le",  in_ready_le,  exp_rdy);
    chk("in_ready_be",  in_ready_be,  exp_rdy);
    chk("out_valid_le", out_valid_le, ev);
    chk("out_valid_be", out_valid_be, ev);
    if (ev) begin
      chk("out_data_le", out_data_le, wq[0].dle);
      chk("out_data_be", out_data_be, wq[0].dbe);
      chk("out_keep_le", out_keep_le, wq[0].kle);
      chk("out_keep_be", out_keep_be, wq[0].kbe);
      chk("out_last_le", out_last_le, wq[0].last);
      chk("out_last_be", out_last_be, wq[0].last);
    end
    accepted = in_valid && exp_rdy && !rst;
    xf       = ev && out_ready;
    s_rst    = rst;
    s_data   = in_data;
    s_last   = in_last;
    @(posedge clk);
    if (s_rst) begin
      pend.delete();
      wq.delete();
    end else begin
      if (xf) void'(wq.pop_front());
      if (accepted) begin
        pend.push_back(s_data);
        if (s_last || pend.size() == 4) make_word(s_last);
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic send(input logic [7:0] b, input logic lst);
    bit a;
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = lst;
    for (int i = 0; i < 50 && !done; i++) begin
      step(a);
      done = a;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int acc_cnt;
    int cyc;
    bit a;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid_le, 0);
    chk("rst_data",  out_data_le,  0);
    chk("rst_keep",  out_keep_le,  0);
    chk("rst_last",  out_last_le,  0);
    chk("rst_ready", in_ready_le,  1);
    rst = 1'b0;
    idle(2);

    // Four bytes back to back, both lane orders.
    in_valid = 1'b1; in_last = 1'b0; in_data = 8'h11; step(a);
    in_data = 8'h22; step(a);
    in_data = 8'h33; step(a);
    in_data = 8'h44; in_last = 1'b1; step(a);
    in_valid = 1'b0; in_last = 1'b0;
    chk("full_valid",   out_valid_le, 1);
    chk("full_data_le", out_data_le, 32'h44332211);
    chk("full_keep_le", out_keep_le, 4'hF);
    chk("full_last",    out_last_le, 1);
    chk("full_data_be", out_data_be, 32'h11223344);
    chk("full_keep_be", out_keep_be, 4'hF);
    chk("full_bswap",   {out_data_be[7:0], out_data_be[15:8], out_data_be[23:16], out_data_be[31:24]},
        32'h44332211);
    idle(2);

    // Two-byte packet.
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    chk("two_data_le", out_data_le, 32'h0000BBAA);
    chk("two_keep_le", out_keep_le, 4'b0011);
    chk("two_last",    out_last_le, 1);
    chk("two_data_be", out_data_be, 32'hAABB0000);
    chk("two_keep_be", out_keep_be, 4'b1100);
    idle(2);

    // Single-byte packet.
    send(8'h5A, 1'b1);
    chk("one_data_le", out_data_le, 32'h0000005A);
    chk("one_keep_le", out_keep_le, 4'b0001);
    chk("one_keep_be", out_keep_be, 4'b1000);
    chk("one_last",    out_last_le, 1);
    idle(2);

    // Backpressure after the first word of an 8-byte stream.
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h05;
    for (int i = 0; i < 3; i++) begin
      step(a);
      chk("bp_in_ready", in_ready_le, 0);
      chk("bp_hold",     out_data_le, 32'h04030201);
    end
    out_ready = 1'b1;
    for (int i = 5; i <= 8; i++) send(8'(i), i == 8);
    chk("bp_word2",      out_data_le, 32'h08070605);
    chk("bp_word2_last", out_last_le, 1);
    idle(2);

    // Reset mid-packet discards the partial word.
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    rst = 1'b1;
    step(a);
    rst = 1'b0;
    chk("mid_rst_valid", out_valid_le, 0);
    chk("mid_rst_ready", in_ready_le,  1);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    send(8'hC4, 1'b1);
    chk("post_rst_data", out_data_le, 32'hC4C3C2C1);
    chk("post_rst_keep", out_keep_le, 4'hF);
    idle(2);

    // Reset discards a word held by backpressure.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'hD0 + 8'(i), 1'b0);
    chk("held_valid", out_valid_le, 1);
    rst = 1'b1;
    step(a);
    rst = 1'b0;
    out_ready = 1'b1;
    chk("held_rst_valid", out_valid_le, 0);
    chk("held_rst_data",  out_data_le,  0);
    idle(2);

    // Random traffic against the reference.
    acc_cnt = 0;
    cyc     = 0;
    while (acc_cnt < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      in_last   = ($urandom_range(0, 9) < 2);
      in_data   = 8'($urandom);
      step(a);
      if (a) acc_cnt++;
      cyc++;
    end
    chk("random_budget", 32'(acc_cnt >= 1000), 1);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    idle(3);
    chk("drain_empty", 32'(wq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
